// File: rtl/matmul_sequencer.sv
// Address/control sequencer for an NxN matrix multiply C = A*B.
// Issues operand reads in i/j/k loop order and pipelines MAC and write-back strobes.
module matmul_sequencer #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N),
    localparam int AW = 2 * IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clr,
    input  logic          pause,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   i_q, j_q, k_q;
    logic            s1_valid, s1_first, s1_last;
    logic [AW-1:0]   s1_addr;
    logic            wr_q;
    logic [AW-1:0]   wr_addr_q;
    logic            issue_fire;
    logic            last_issue;

    assign issue_fire = (state == ISSUE) && !pause;
    assign last_issue = issue_fire && (i_q == '1) && (j_q == '1) && (k_q == '1);

    // NOTE: every output is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        rd_en  = issue_fire;
        a_addr = '0;
        b_addr = '0;
        if (state == ISSUE) begin
            a_addr = {i_q, k_q};
            b_addr = {k_q, j_q};
        end
    end

    assign mac_en    = s1_valid;
    assign mac_first = s1_valid && s1_first;
    assign wr_en     = wr_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_addr   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
        end else if (clr) begin
            state     <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_addr   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            // Two-stage strobe pipeline drains every cycle; pause only creates a bubble.
            s1_valid  <= issue_fire;
            s1_first  <= issue_fire && (k_q == '0);
            s1_last   <= issue_fire && (k_q == '1);
            s1_addr   <= {i_q, j_q};
            wr_q      <= s1_valid && s1_last;
            wr_addr_q <= (s1_valid && s1_last) ? s1_addr : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        k_q <= k_q + 1'b1;
                        if (k_q == '1) begin
                            j_q <= j_q + 1'b1;
                            if (j_q == '1) begin
                                i_q <= i_q + 1'b1;
                            end
                        end
                        if (last_issue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means the final write is on the outputs now.
                    if (!s1_valid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: matrix dimension; power of two, 2..16.
REQ-002 SHALL have derived localparams IW = log2(N) (index width) and AW = 2*IW (address width).
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request one NxN multiply C = A*B; honoured only in IDLE.
REQ-006 SHALL have port clr, input, 1: synchronous abort to IDLE.
REQ-007 SHALL have port pause, input, 1: suppresses new read issue for the current cycle.
REQ-008 SHALL have port rd_en, output, 1: operand memories sample a_addr/b_addr this cycle.
REQ-009 SHALL have port a_addr, output, AW: A address {i,k} (row-major, i*N+k).
REQ-010 SHALL have port b_addr, output, AW: B address {k,j}.
REQ-011 SHALL have port mac_en, output, 1: datapath consumes read data this cycle.
REQ-012 SHALL have port mac_first, output, 1: qualifies mac_en; datapath loads the product instead of accumulating.
REQ-013 SHALL have port wr_en, output, 1: accumulator result is written to C.
REQ-014 SHALL have port wr_addr, output, AW: C address {i,j}.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-018 SHALL, in IDLE, go to ISSUE when start=1, with loop counters i=j=k=0.
REQ-019 SHALL, in ISSUE, drive rd_en = ~pause, a_addr = {i,k} and b_addr = {k,j} combinationally from the counters.
REQ-020 SHALL advance the loop nest (k inner, j middle, i outer, each wrapping N-1->0) on each ISSUE cycle with rd_en=1.
REQ-021 SHALL, when pause=1 in ISSUE, hold the counters and addresses unchanged and insert a bubble into the pipeline.
REQ-022 SHALL go from ISSUE to DRAIN on the cycle that issues i=j=k=N-1 with rd_en=1.
REQ-023 SHALL assert mac_en one cycle after each rd_en=1 cycle, with mac_first=1 iff that issue had k=0.
REQ-024 SHALL assert wr_en two cycles after each issue with k=N-1, with wr_addr={i,j} of that issue.
REQ-025 SHALL drain the pipeline stages every cycle regardless of pause; pause has no effect outside ISSUE.
REQ-026 SHALL stay in DRAIN until the final wr_en has been emitted, then enter DONE on the next cycle.
REQ-027 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-028 SHALL ignore start in ISSUE, DRAIN and DONE (no restart, no queueing).
REQ-029 SHALL, on clr=1 in any state, enter IDLE next cycle, zero the counters, invalidate the pipeline (no further mac_en/wr_en) and suppress done.
REQ-030 SHALL give clr priority over start when both are high.
REQ-031 SHALL hold wr_addr at 0 whenever wr_en=0.
REQ-032 SHALL emit exactly N^3 mac_en pulses and N^2 wr_en pulses per uninterrupted job.
REQ-033 SHALL complete an unpaused job with done at cycle N^3+3, where start is sampled at cycle 0.

Reset
REQ-034 SHALL, while rst=1, force state=IDLE, counters=0, pipeline valids=0, and all outputs (rd_en, a_addr, b_addr, mac_en, mac_first, wr_en, wr_addr, busy, done) to 0.
REQ-035 SHALL, on rst asserted mid-job, abandon the job with no done pulse; a new start is required afterwards.

Verification
REQ-036 SHALL cover: N=2, start at cycle 0 -> rd_en cycles 1-8; (a,b) = (0,0),(1,2),(0,1),(1,3),(2,0),(3,2),(2,1),(3,3); mac_first at cycles 2,4,6,8; wr_addr 0,1,2,3 at cycles 4,6,8,10; done only at cycle 11.
REQ-037 SHALL cover: N=2, pause=1 at cycles 3-4 -> addresses hold (0,1) through cycle 5; mac_en low at cycles 4-5; done at cycle 13; exactly 8 mac_en and 4 wr_en pulses.
REQ-038 SHALL cover: start pulsed at cycles 1-6 during a job -> trace identical to the first scenario.
REQ-039 SHALL cover: clr at cycle 5 -> IDLE at cycle 6; at most one stage-1 mac_en and no wr_en after cycle 5; no done; busy=0 from cycle 6.
REQ-040 SHALL cover: rst asserted at cycle 3 -> all outputs 0 asynchronously; a new start after release runs a complete correct job.
REQ-041 SHALL cover: N=4, back-to-back start immediately after done -> 64 mac_en and 16 wr_en pulses with wr_addr 0..15 in order, and done at cycle 67 relative to each start.
